// File: rtl/prs_descrambler_if.sv
// Stream and control bundle for the PRS descrambler: configuration, bit-in/bit-out
// handshakes and status.
interface prs_descrambler_if #(
  parameter int LEN_W = 16
) ();
  logic             start;
  logic [30:0]      c_init;
  logic [LEN_W-1:0] seq_len;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             busy;
  logic             done;

  modport master (
    output start, c_init, seq_len, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, busy, done
  );

  modport slave (
    input  start, c_init, seq_len, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, busy, done
  );
endinterface

// File: rtl/prs_descrambler.sv
// Serial 3GPP Gold-sequence descrambler: NC warm-up steps after each load, then
// XORs c(n) onto each accepted input bit into a single-entry output register.
module prs_descrambler #(
  parameter int NC    = 1600,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  prs_descrambler_if.slave   bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WARMUP = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;

  localparam logic [10:0] WARM_LAST = 11'(NC - 1);
  localparam logic [10:0] WARM_END  = 11'(NC);

  logic [1:0]       state;
  logic [30:0]      x1;
  logic [30:0]      x2;
  logic [10:0]      warm_cnt;
  logic [LEN_W-1:0] remain;
  logic             out_valid_q;
  logic             out_bit_q;
  logic             done_q;

  logic c_bit;
  logic hs;
  logic warm_step;

  assign c_bit     = x1[0] ^ x2[0];
  assign bus.in_ready = (state == RUN) && (!out_valid_q || bus.out_ready);
  assign hs        = bus.in_valid && bus.in_ready;
  // With seq_len == 0 the counter parks at NC for one extra, non-stepping cycle
  // before returning to IDLE with done.
  assign warm_step = (state == WARMUP) && (warm_cnt != WARM_END);

  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x1          <= '0;
      x2          <= '0;
      warm_cnt    <= '0;
      remain      <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (warm_step || hs) begin
        x1 <= {x1[3] ^ x1[0], x1[30:1]};
        x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            x1       <= 31'd1;
            x2       <= bus.c_init;
            remain   <= bus.seq_len;
            warm_cnt <= '0;
            state    <= WARMUP;
          end
        end
        WARMUP: begin
          if (warm_cnt == WARM_END) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + 11'd1;
            if ((warm_cnt == WARM_LAST) && (remain != '0))
              state <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            remain <= remain - 1'b1;
            if (remain == LEN_W'(1)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Output register drains independently of state so a pending bit survives IDLE.
      if (hs) begin
        out_bit_q   <= bus.in_bit ^ c_bit;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prs_descrambler.sv
// Randomized bench for prs_descrambler against a direct evaluation of the
// Gold-sequence recurrences x1(n+31), x2(n+31), c(n) = x1(n+Nc) ^ x2(n+Nc).
module tb_prs_descrambler;
  localparam int NC    = 1600;
  localparam int LEN_W = 16;
  localparam int MAXN  = 1100;
  localparam int MAXL  = NC + MAXN + 31;

  logic clk;
  logic rst;

  prs_descrambler_if #(.LEN_W(LEN_W)) bus ();

  prs_descrambler #(.NC(NC), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit gx1  [0:MAXL-1];
  bit gx2  [0:MAXL-1];
  bit gseq [0:MAXN-1];

  bit in_bits[$];
  bit out_bits[$];
  bit orig_bits[$];
  int first_rdy, done_cyc, done_cnt, busy_fall, unstable, extra_hs, timeout, last_hs;
  bit busy0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_seq(input bit [30:0] ci, input int len);
    for (int i = 0; i < 31; i++) begin
      gx1[i] = (i == 0);
      gx2[i] = ci[i];
    end
    for (int n = 0; n < NC + len; n++) begin
      gx1[n+31] = gx1[n+3] ^ gx1[n];
      gx2[n+31] = gx2[n+3] ^ gx2[n+2] ^ gx2[n+1] ^ gx2[n];
    end
    for (int n = 0; n < len; n++) gseq[n] = gx1[n+NC] ^ gx2[n+NC];
  endtask

  task automatic fill_random(input int len);
    in_bits.delete();
    for (int i = 0; i < len; i++) in_bits.push_back(1'($urandom));
  endtask

  // Runs one codeword from a start pulse until done has been seen and the output
  // has drained; records observations only, the caller judges them.
  task automatic drive_stream(input bit [30:0] ci, input int len, input int iv_pct,
                              input int stall_pct, input int rs1, input int rs2,
                              input bit [30:0] alt);
    int idx, tail;
    bit pov, pob, por, fin;
    out_bits.delete();
    first_rdy = -1; done_cyc = -1; done_cnt = 0; busy_fall = -1;
    unstable = 0; extra_hs = 0; timeout = 0; last_hs = -1;
    bus.c_init = ci; bus.seq_len = LEN_W'(len); bus.start = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    busy0 = bus.busy;
    idx = 0; tail = -1; fin = 1'b0; pov = 1'b0; pob = 1'b0; por = 1'b1;
    for (int cyc = 0; cyc < NC + 40 * len + 200 && !fin; cyc++) begin
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc > 0 && busy_fall < 0 && !bus.busy) busy_fall = cyc;
      if (pov && !por && (!bus.out_valid || bus.out_bit !== pob)) unstable++;
      if (tail < 0 && done_cyc >= 0 && idx >= len && !bus.out_valid) tail = 4;
      if (tail > 0) tail--;
      if (tail == 0) fin = 1'b1;
      if (!fin) begin
        bus.start     = (cyc == rs1) || (cyc == rs2);
        bus.c_init    = bus.start ? alt : ci;
        bus.seq_len   = bus.start ? LEN_W'(7) : LEN_W'(len);
        bus.in_valid  = ($urandom_range(99) < iv_pct);
        bus.in_bit    = (idx < len) ? in_bits[idx] : 1'($urandom);
        bus.out_ready = ($urandom_range(99) >= stall_pct);
        #1;
        if (bus.in_ready && first_rdy < 0) first_rdy = cyc;
        if (bus.out_valid && bus.out_ready) out_bits.push_back(bus.out_bit);
        if (bus.in_valid && bus.in_ready) begin
          if (idx < len) idx++;
          else extra_hs++;
          last_hs = cyc + 1;
        end
        pov = bus.out_valid; pob = bus.out_bit; por = bus.out_ready;
        tick();
      end
    end
    if (!fin) timeout = 1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_out_bit got=%b exp=0", bus.out_bit); end
  endtask

  task automatic test_basic();
    gen_seq(31'd0, 8);
    in_bits.delete();
    for (int i = 0; i < 8; i++) in_bits.push_back(1'b0);
    drive_stream(31'd0, 8, 100, 0, -1, -1, 31'd0);
    n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL basic_timeout got=%0d exp=0", timeout); end
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got=%b exp=1", busy0); end
    n_checks++; if (first_rdy !== NC) begin n_fail++; $display("FAIL basic_first_ready got=%0d exp=%0d", first_rdy, NC); end
    n_checks++; if (out_bits.size() !== 8) begin n_fail++; $display("FAIL basic_count got=%0d exp=8", out_bits.size()); end
    for (int i = 0; i < 8 && i < out_bits.size(); i++) begin
      n_checks++;
      if (out_bits[i] !== gseq[i]) begin n_fail++; $display("FAIL basic_bit[%0d] got=%b exp=%b", i, out_bits[i], gseq[i]); end
    end
    n_checks++; if (last_hs !== NC + 8) begin n_fail++; $display("FAIL basic_last_hs got=%0d exp=%0d", last_hs, NC + 8); end
    n_checks++; if (done_cyc !== NC + 8) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, NC + 8); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    n_checks++; if (busy_fall !== NC + 8) begin n_fail++; $display("FAIL basic_busy_fall got=%0d exp=%0d", busy_fall, NC + 8); end
  endtask

  task automatic test_long_roundtrip();
    bit [30:0] ci = 31'h1234567;
    gen_seq(ci, 1000);
    fill_random(1000);
    drive_stream(ci, 1000, 80, 0, -1, -1, 31'd0);
    n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL long_timeout got=%0d exp=0", timeout); end
    n_checks++; if (out_bits.size() !== 1000) begin n_fail++; $display("FAIL long_count got=%0d exp=1000", out_bits.size()); end
    for (int i = 0; i < 1000 && i < out_bits.size(); i++) begin
      n_checks++;
      if ((out_bits[i] ^ in_bits[i]) !== gseq[i]) begin
        n_fail++; $display("FAIL long_seq[%0d] got=%b exp=%b", i, out_bits[i] ^ in_bits[i], gseq[i]);
      end
    end
    orig_bits = in_bits;
    in_bits = out_bits;
    drive_stream(ci, 1000, 90, 0, -1, -1, 31'd0);
    n_checks++; if (out_bits.size() !== 1000) begin n_fail++; $display("FAIL roundtrip_count got=%0d exp=1000", out_bits.size()); end
    for (int i = 0; i < 1000 && i < out_bits.size(); i++) begin
      n_checks++;
      if (out_bits[i] !== orig_bits[i]) begin n_fail++; $display("FAIL roundtrip[%0d] got=%b exp=%b", i, out_bits[i], orig_bits[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit [30:0] ci = 31'h2F0C3A1;
    gen_seq(ci, 500);
    fill_random(500);
    drive_stream(ci, 500, 50, 50, -1, -1, 31'd0);
    n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL bp_timeout got=%0d exp=0", timeout); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
    n_checks++; if (extra_hs !== 0) begin n_fail++; $display("FAIL bp_extra_accept got=%0d exp=0", extra_hs); end
    n_checks++; if (out_bits.size() !== 500) begin n_fail++; $display("FAIL bp_count got=%0d exp=500", out_bits.size()); end
    for (int i = 0; i < 500 && i < out_bits.size(); i++) begin
      n_checks++;
      if (out_bits[i] !== (in_bits[i] ^ gseq[i])) begin
        n_fail++; $display("FAIL bp_bit[%0d] got=%b exp=%b", i, out_bits[i], in_bits[i] ^ gseq[i]);
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    n_checks++; if (done_cyc !== last_hs) begin n_fail++; $display("FAIL bp_done_cycle got=%0d exp=%0d", done_cyc, last_hs); end
  endtask

  task automatic test_zero_len();
    in_bits.delete();
    drive_stream(31'h0ABCDEF, 0, 100, 0, -1, -1, 31'd0);
    n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL zero_timeout got=%0d exp=0", timeout); end
    n_checks++; if (first_rdy !== -1) begin n_fail++; $display("FAIL zero_in_ready got=%0d exp=-1", first_rdy); end
    n_checks++; if (done_cyc !== NC + 1) begin n_fail++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, NC + 1); end
    n_checks++; if (busy_fall !== NC + 1) begin n_fail++; $display("FAIL zero_busy_fall got=%0d exp=%0d", busy_fall, NC + 1); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
    n_checks++; if (out_bits.size() !== 0) begin n_fail++; $display("FAIL zero_outputs got=%0d exp=0", out_bits.size()); end
  endtask

  task automatic test_restart_ignored();
    bit [30:0] ci = 31'h3D5A961;
    gen_seq(ci, 100);
    fill_random(100);
    drive_stream(ci, 100, 100, 0, 800, NC + 50, 31'h7ABCDEF);
    n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL restart_timeout got=%0d exp=0", timeout); end
    n_checks++; if (out_bits.size() !== 100) begin n_fail++; $display("FAIL restart_count got=%0d exp=100", out_bits.size()); end
    for (int i = 0; i < 100 && i < out_bits.size(); i++) begin
      n_checks++;
      if (out_bits[i] !== (in_bits[i] ^ gseq[i])) begin
        n_fail++; $display("FAIL restart_bit[%0d] got=%b exp=%b", i, out_bits[i], in_bits[i] ^ gseq[i]);
      end
    end
    n_checks++; if (last_hs !== NC + 100) begin n_fail++; $display("FAIL restart_last_hs got=%0d exp=%0d", last_hs, NC + 100); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    bit [30:0] ci = 31'h55AA55A;
    // Reset at cycle 800 of warm-up.
    bus.c_init = ci; bus.seq_len = LEN_W'(40); bus.start = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (800) tick();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstw_done got=%b exp=0", bus.done); end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin tick(); if (bus.done || bus.busy) saw_done = 1'b1; end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstw_quiet got=%b exp=0", saw_done); end
    // Reset mid-run with a pending output held by backpressure.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    repeat (NC + 10) tick();
    bus.out_ready = 1'b0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstr_pending got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstr_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_bit !== 1'b0) begin n_fail++; $display("FAIL rstr_out_bit got=%b exp=0", bus.out_bit); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstr_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstr_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstr_done got=%b exp=0", bus.done); end
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    saw_done = 1'b0;
    repeat (5) begin tick(); if (bus.done) saw_done = 1'b1; end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstr_no_done got=%b exp=0", saw_done); end
    // A fresh start must produce the sequence from n = 0.
    gen_seq(ci, 20);
    fill_random(20);
    drive_stream(ci, 20, 70, 30, -1, -1, 31'd0);
    n_checks++; if (out_bits.size() !== 20) begin n_fail++; $display("FAIL rst_after_count got=%0d exp=20", out_bits.size()); end
    for (int i = 0; i < 20 && i < out_bits.size(); i++) begin
      n_checks++;
      if (out_bits[i] !== (in_bits[i] ^ gseq[i])) begin
        n_fail++; $display("FAIL rst_after_bit[%0d] got=%b exp=%b", i, out_bits[i], in_bits[i] ^ gseq[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.c_init = '0; bus.seq_len = '0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_long_roundtrip();
    test_backpressure();
    test_zero_len();
    test_restart_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prs_descrambler.md
# prs_descrambler

Receive-side counterpart to the DMRS pseudo-random sequence generator. It generates the 3GPP length-31 Gold sequence c(n) serially, with the full Nc = 1600 warm-up advanced one step per clock, and XORs it onto an incoming bit stream to descramble PUSCH soft-decision sign bits. It sits between the demapper and the rate-recovery stage, and is loaded with c_init once per codeword.

## Interface
- NC, 1600: Gold-sequence warm-up length in LFSR steps.
- LEN_W, 16: width of the sequence-length field.

- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request to load a new sequence. Sampled only in IDLE.
- c_init, input, 31: x2 initial state. Sampled with start.
- seq_len, input, LEN_W: number of bits to descramble. Sampled with start.
- in_valid, input, 1: in_bit valid.
- in_ready, output, 1: block accepts in_bit this cycle.
- in_bit, input, 1: scrambled bit.
- out_valid, output, 1: out_bit valid.
- out_ready, input, 1: downstream accepts out_bit.
- out_bit, output, 1: descrambled bit, in_bit ^ c(n).
- busy, output, 1: high in WARMUP and RUN.
- done, output, 1: one-cycle pulse after the last input bit is accepted.

## Operation
- State machine: IDLE -> WARMUP -> RUN -> IDLE.
- IDLE, start high:
  - load x1 = 31'd1 and x2 = c_init;
  - latch seq_len into the remaining-count register;
  - clear the warm-up counter;
  - go to WARMUP.
- WARMUP: advance both LFSRs one step per cycle. Warm-up counter is 11 bits. After exactly NC steps, go to RUN. If latched seq_len == 0, go to IDLE instead and pulse done.
- LFSR step (all bit indices LSB-first, shift right):
  - x1 <= {x1[3]^x1[0], x1[30:1]};
  - x2 <= {x2[3]^x2[2]^x2[1]^x2[0], x2[30:1]}.
- Current sequence bit: c = x1[0] ^ x2[0].
- RUN:
  - in_ready = !out_valid || out_ready.
  - On an input handshake (in_valid && in_ready):
    - out_bit <= in_bit ^ c;
    - out_valid <= 1;
    - both LFSRs step once;
    - remaining-count decrements.
  - When the count reaches 0 on a handshake, go to IDLE and pulse done in the following cycle.
- Output register:
  - out_valid clears on out_ready when there is no new handshake.
  - out_valid and out_bit hold stable while out_ready is low.
  - A pending output may remain valid after return to IDLE; it drains normally.
- in_ready is 0 outside RUN.
- start outside IDLE is ignored; configuration does not change.
- start in IDLE while an output is still pending is accepted.
- LFSR state is never advanced without a warm-up step or an input handshake.

## Timing
- Reset values: all outputs 0; state IDLE; x1, x2 and counters 0.
- start is sampled at edge k. busy rises after edge k. in_ready is high at the earliest after edge k+NC, i.e. the first RUN cycle.
- Data latency: in_bit accepted at edge m appears on out_bit/out_valid after edge m.
- Throughput: one bit per clock while out_ready is held high.
- done is high for exactly one cycle, the cycle after the final handshake edge. busy is low in that same cycle.
- Reset asserted mid-WARMUP or mid-RUN:
  - immediate return to IDLE;
  - outputs cleared;
  - a pending out_valid is dropped;
  - no done pulse.

## Test plan
- start with c_init = 0 and seq_len = 8, in_valid held high, all in_bit = 0. Required:
  - in_ready rises exactly 1600 cycles after the start edge;
  - out_bit equals the golden model c(0..7) for c_init = 0;
  - done pulses one cycle after the 8th handshake.
- c_init = 0x1234567, seq_len = 1000, random in_bit. Required:
  - out_bit ^ in_bit matches the 3GPP 38.211 §5.2.1 model bit-exactly;
  - feeding out_bit back through a second run returns the original bits.
- Backpressure: toggle out_ready randomly (about 50%) with in_valid random.
  - out_bit must stay stable while out_valid is high and out_ready is low.
  - No bit may be lost or duplicated.
  - Sequence alignment must be preserved over 500 bits.
- seq_len = 0. Required: no in_ready at any point; done pulses 1601 cycles after start; busy falls at the same time.
- start pulsed again during WARMUP and during RUN with a different c_init. Required: ignored, and the output matches the original c_init sequence.
- rst asserted at cycle 800 of WARMUP, and again mid-RUN. Required:
  - all outputs 0 next cycle, no done pulse;
  - a subsequent start produces the correct sequence from n = 0.
